led_frame_sequencer: RTL
========================

LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, number of pixels per frame (1..255).
REQ-002 SHALL have parameter HUE_STEP, default 8, 8-bit hue increment between adjacent pixels.
REQ-003 SHALL have parameter CONV_LATENCY, default 3, clocks from HSV applied to conv_rgb valid (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  frame request; sampled only in IDLE.
REQ-007 SHALL have port hue_speed  input  8  hue_base advance per completed frame.
REQ-008 SHALL have port sat  input  8  saturation for the frame, latched at start.
REQ-009 SHALL have port val  input  8  brightness for the frame, latched at start.
REQ-010 SHALL have port conv_h, conv_s, conv_v  output  8 each  HSV operands to the HSV-to-RGB converter.
REQ-011 SHALL have port conv_rgb  input  24  GRB result from the converter.
REQ-012 SHALL have port pix_data  output  24  GRB word to the WS2812B serialiser.
REQ-013 SHALL have port pix_valid  output  1  pix_data holds a valid pixel.
REQ-014 SHALL have port pix_ready  input  1  serialiser accepts pix_data this cycle.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, PUSH, DONE.
REQ-018 IDLE: start=1 SHALL latch sat/val, clear pixel index idx to 0, and go to ISSUE next cycle; start=0 SHALL keep IDLE.
REQ-019 ISSUE: SHALL drive conv_h = (hue_base + idx*HUE_STEP) mod 256, conv_s = latched sat, conv_v = latched val, load wait counter to CONV_LATENCY, and go to WAIT.
REQ-020 conv_h/s/v SHALL stay constant from ISSUE until the pixel's PUSH state exits (converter has no valid strobe).
REQ-021 WAIT: SHALL decrement the counter each cycle; at 1 it SHALL capture conv_rgb into pix_data and enter PUSH, giving exactly CONV_LATENCY cycles from the ISSUE cycle to capture.
REQ-022 PUSH: pix_valid SHALL be 1 and pix_data stable until a cycle with pix_ready=1 (transfer).
REQ-023 On transfer with idx < NUM_LEDS-1: SHALL increment idx, deassert pix_valid next cycle, go to ISSUE.
REQ-024 On transfer with idx = NUM_LEDS-1: SHALL deassert pix_valid next cycle and go to DONE.
REQ-025 DONE: SHALL assert frame_done for exactly one cycle, update hue_base = (hue_base + hue_speed) mod 256, return to IDLE.
REQ-026 pix_ready while pix_valid=0 SHALL be ignored.
REQ-027 start asserted outside IDLE SHALL be ignored (not queued).
REQ-028 Hue arithmetic SHALL wrap modulo 256 with no saturation; idx*HUE_STEP computed at 16 bits then truncated.
REQ-029 Per frame exactly NUM_LEDS transfers SHALL occur, in idx order 0..NUM_LEDS-1.
REQ-030 sat/val/hue_speed changes mid-frame SHALL not affect the current frame; hue_speed is sampled in DONE.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE regardless of state, including mid-PUSH.
REQ-032 Reset values SHALL be: pix_valid=0, pix_data=0, frame_done=0, busy=0, conv_h/s/v=0, hue_base=0, idx=0, wait counter=0, latched sat/val=0.
REQ-033 After reset release, no pixel SHALL be emitted until a new start in IDLE.

Verification
REQ-034 Defaults, hue_speed=0, sat=255, val=255, pix_ready=1, start pulse -> 8 transfers, conv_h sequence 0,8,...,56, frame_done 1 cycle after last transfer, busy then low.
REQ-035 Latency check with reference converter model: each pix_data equals model(conv_h,conv_s,conv_v); capture exactly 3 cycles after ISSUE.
REQ-036 Backpressure: pix_ready held 0 for 10 cycles on pixel 3 -> pix_valid stays 1, pix_data and conv_h (=24) constant, no idx advance.
REQ-037 Hue wrap: hue_speed=200, run 2 frames -> frame 2 pixel 0 conv_h=200, pixel 7 conv_h=(200+56) mod 256=0.
REQ-038 Reset mid-frame: rst_n=0 during PUSH of pixel 4 -> next cycle pix_valid=0, busy=0, hue_base=0; new start restarts at pixel 0, conv_h=0.
REQ-039 start held high continuously -> frames back-to-back with one IDLE cycle between, start during busy never aborts or duplicates a frame.

Source files
------------

// File: rtl/led_frame_sequencer.sv
// Walks one frame of NUM_LEDS pixels: issues an HSV triple per pixel to an external
// fixed-latency converter, captures the GRB result and hands it to a serialiser.
module led_frame_sequencer #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned HUE_STEP     = 8,
  parameter int unsigned CONV_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  hue_speed,
  input  logic [7:0]  sat,
  input  logic [7:0]  val,
  output logic [7:0]  conv_h,
  output logic [7:0]  conv_s,
  output logic [7:0]  conv_v,
  input  logic [23:0] conv_rgb,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  dbg_state
);

  localparam int unsigned CW       = $clog2(CONV_LATENCY + 1);
  localparam logic [7:0]  LAST_IDX = 8'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_PUSH  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    hue_base_q, hue_base_d;
  logic [7:0]    sat_q, sat_d;
  logic [7:0]    val_q, val_d;
  logic [7:0]    conv_h_q, conv_h_d;
  logic [7:0]    conv_s_q, conv_s_d;
  logic [7:0]    conv_v_q, conv_v_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [23:0]   pix_data_q, pix_data_d;
  logic [7:0]    next_idx;
  logic [15:0]   hue_ofs;
  logic          xfer;

  // Handshake: a pixel moves on a cycle where pix_valid and pix_ready are both 1;
  // pix_data is held while pix_valid is 1, and pix_ready is ignored otherwise.
  assign xfer = (state_q == S_PUSH) && pix_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 8'd0;
      hue_base_q <= 8'd0;
      sat_q      <= 8'd0;
      val_q      <= 8'd0;
      conv_h_q   <= 8'd0;
      conv_s_q   <= 8'd0;
      conv_v_q   <= 8'd0;
      wait_q     <= '0;
      pix_data_q <= 24'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hue_base_q <= hue_base_d;
      sat_q      <= sat_d;
      val_q      <= val_d;
      conv_h_q   <= conv_h_d;
      conv_s_q   <= conv_s_d;
      conv_v_q   <= conv_v_d;
      wait_q     <= wait_d;
      pix_data_q <= pix_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_q == CW'(1)) state_d = S_PUSH;
      S_PUSH:  if (xfer) state_d = (idx_q == LAST_IDX) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The converter has no strobe, so conv_* are loaded on entry to ISSUE and then
  // held untouched until the pixel has been handed over.
  always_comb begin
    idx_d      = idx_q;
    hue_base_d = hue_base_q;
    sat_d      = sat_q;
    val_d      = val_q;
    conv_h_d   = conv_h_q;
    conv_s_d   = conv_s_q;
    conv_v_d   = conv_v_q;
    wait_d     = wait_q;
    pix_data_d = pix_data_q;
    next_idx   = (state_q == S_IDLE) ? 8'd0 : idx_q + 8'd1;
    hue_ofs    = 16'(next_idx) * 16'(HUE_STEP);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sat_d    = sat;
          val_d    = val;
          idx_d    = 8'd0;
          conv_h_d = 8'(hue_base_q + hue_ofs);
          conv_s_d = sat;
          conv_v_d = val;
        end
      end
      S_ISSUE: wait_d = CW'(CONV_LATENCY);
      S_WAIT: begin
        wait_d = wait_q - CW'(1);
        if (wait_q == CW'(1)) pix_data_d = conv_rgb;
      end
      S_PUSH: begin
        if (xfer && (idx_q != LAST_IDX)) begin
          idx_d    = next_idx;
          conv_h_d = 8'(hue_base_q + hue_ofs);
          conv_s_d = sat_q;
          conv_v_d = val_q;
        end
      end
      S_DONE:  hue_base_d = hue_base_q + hue_speed;
      default: ;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    pix_valid  = (state_q == S_PUSH);
    frame_done = (state_q == S_DONE);
    dbg_state  = state_q;
  end

  assign conv_h   = conv_h_q;
  assign conv_s   = conv_s_q;
  assign conv_v   = conv_v_q;
  assign pix_data = pix_data_q;

endmodule
